// File: rtl/par_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : par_serial_if
//  Description : Byte-side and serial-side signal bundle of the parallel to
//                serial transmit stage.
//                  data_in      [7:0]  byte from the upstream arbitration mux
//                  valid_in            qualifies data_in on a frame-load edge
//                  data_out            serial bit, MSB first
//                  frame_strobe        marks the bit-7 cycle of every frame
//                  frame_valid         high for the 8 cycles of a data frame
//                  sync_done           all start-up COM frames have been sent
//                master : drives the byte side (upstream / testbench)
//                slave  : the transmit stage itself
//  Revision    : 1.0  initial release
// ============================================================================
interface par_serial_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       frame_strobe;
    logic       frame_valid;
    logic       sync_done;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  frame_strobe,
        input  frame_valid,
        input  sync_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output frame_strobe,
        output frame_valid,
        output sync_done
    );
endinterface
`default_nettype wire

// File: rtl/par_serial.sv
`default_nettype none
// ============================================================================
//  Module      : par_serial
//  Description : Parallel-to-serial transmit stage. Every 8 bit-clocks a byte
//                is loaded and shifted out MSB first. After reset a fixed
//                number of COM (IDLE_CHAR) frames is sent so the far-end
//                receiver can lock; afterwards each frame carries data_in
//                when valid_in is high on the load edge, COM otherwise.
//  Ports       : clk    - bit clock (8x byte rate), rising edge
//                reset  - asynchronous, active-high, clears all state
//                bus    - par_serial_if.slave (byte in, serial/status out)
//  Parameters  : IDLE_CHAR   - COM byte for idle and sync frames
//                SYNC_FRAMES - number of COM frames after reset (1..15)
//  Revision    : 1.0  initial release
// ============================================================================
module par_serial #(
    parameter logic [7:0]  IDLE_CHAR   = 8'hBC,
    parameter int unsigned SYNC_FRAMES = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    par_serial_if.slave      bus
);

    localparam logic [3:0] C_SYNC_FRAMES = 4'(SYNC_FRAMES);
    localparam logic [3:0] C_SYNC_MAX    = 4'hF;
    localparam logic [2:0] C_LAST_BIT    = 3'd7;

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_data_out;
    logic       r_frame_strobe;
    logic       r_frame_valid;
    logic [3:0] r_sync_cnt;
    logic       r_sync_done;

    logic       w_load;
    logic       w_sync_last;
    logic       w_accept;
    logic [7:0] w_byte_sel;
    logic       w_frame_valid_next;
    logic       w_bit_next;
    logic       w_sync_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_load             = (r_cnt == 3'd0);
        // The load edge that follows the last completed sync frame already
        // behaves as ACTIVE, so the first post-sync frame can carry data.
        w_sync_last        = (r_state == ST_SYNC) && (r_sync_cnt == C_SYNC_FRAMES);
        w_accept           = (r_state == ST_ACTIVE) || w_sync_last;
        w_frame_valid_next = w_accept && bus.valid_in;
        w_byte_sel         = w_frame_valid_next ? bus.data_in : IDLE_CHAR;
        // A sync frame counts as complete once its bit 0 has been driven.
        w_sync_inc         = (r_state == ST_SYNC) && (r_cnt == C_LAST_BIT) &&
                             (r_sync_cnt != C_SYNC_MAX);
        w_bit_next         = w_load ? w_byte_sel[7] : r_shift[C_LAST_BIT - r_cnt];

        case (r_state)
            ST_SYNC: begin
                if (w_load && w_sync_last) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Only reset leaves ACTIVE.
                w_state_next = ST_ACTIVE;
            end
            default: begin
                w_state_next = ST_SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter, shift register, output registers, sync bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= 3'd0;
            r_shift        <= IDLE_CHAR;
            r_data_out     <= 1'b0;
            r_frame_strobe <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_sync_cnt     <= 4'd0;
            r_sync_done    <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + 3'd1;
            r_data_out     <= w_bit_next;
            r_frame_strobe <= w_load;

            if (w_load) begin
                r_shift       <= w_byte_sel;
                r_frame_valid <= w_frame_valid_next;
            end

            if (w_sync_inc) begin
                r_sync_cnt <= r_sync_cnt + 4'd1;
            end

            if (w_load && w_sync_last) begin
                r_sync_done <= 1'b1;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.frame_strobe = r_frame_strobe;
    assign bus.frame_valid  = r_frame_valid;
    assign bus.sync_done    = r_sync_done;

endmodule
`default_nettype wire
